// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtract sequencer: drives an external 1-bit full subtractor
// LSB first, recirculates the borrow and assembles the WIDTH-bit difference.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             fs_a,
  output logic             fs_b,
  output logic             fs_bin,
  input  logic             fs_d,
  input  logic             fs_bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, diff_q;
  logic             brw_q, bout_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_d;

  // The incoming difference bit enters at the MSB so the LSB-first stream
  // ends up correctly aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_d = fs_d;
    end else begin : g_res_wn
      assign res_d = {fs_d, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            brw_q   <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          res_q  <= res_d;
          brw_q  <= fs_bout;
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            diff_q  <= res_d;
            bout_q  <= fs_bout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // busy_q is high exactly while in RUN, so it gates the cell inputs to 0 elsewhere.
  assign fs_a       = busy_q & a_sh_q[0];
  assign fs_b       = busy_q & b_sh_q[0];
  assign fs_bin     = busy_q & brw_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl with a behavioural full-subtractor cell.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow_out, fs_a, fs_b, fs_bin, fs_d, fs_bout;
  logic [W-1:0] diff;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
    .fs_a(fs_a), .fs_b(fs_b), .fs_bin(fs_bin), .fs_d(fs_d), .fs_bout(fs_bout)
  );

  always #5 clk = ~clk;

  assign fs_d    = fs_a ^ fs_b ^ fs_bin;
  assign fs_bout = (~fs_a & fs_b) | (~fs_a & fs_bin) | (fs_b & fs_bin);

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] last_diff = '0;
  logic         last_bout = 1'b0;
  logic [W-1:0] seq_a, seq_b;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bi_n);
    logic [W:0] full;
    full = {1'b0, ai} - {1'b0, bi} - (W+1)'(bi_n);
    return {full[W-1:0], full[W]};
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check_eq("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("diff", diff, e.d);
        check_eq("borrow_out", borrow_out, e.bo);
      end
    end
  end

  // Called #1 after a rising edge. glitch>0 re-pulses start in that RUN cycle;
  // hold keeps start high and returns in the done cycle for a chained start.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bi_n,
                        input int glitch, input bit hold);
    exp_t e;
    e = model(ai, bi, bi_n);
    a = ai; b = bi; bin = bi_n; start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check_eq("diff_held", diff, last_diff);
    check_eq("bout_held", borrow_out, last_bout);
    for (int i = 1; i <= W; i++) begin
      check_eq("busy_run", busy, 1);
      check_eq("done_run", done, 0);
      seq_a[i-1] = fs_a;
      seq_b[i-1] = fs_b;
      if (i == glitch) begin
        start = 1'b1; a = 1; b = 1; bin = 1'b1;
      end else if (!hold) begin
        start = 1'b0; a = ~ai;
      end
      @(posedge clk); #1;
    end
    check_eq("done_pulse", done, 1);
    check_eq("busy_done", busy, 0);
    check_eq("fs_a_idle", fs_a, 0);
    check_eq("fs_a_seq", seq_a, ai);
    check_eq("fs_b_seq", seq_b, bi);
    last_diff = e.d;
    last_bout = e.bo;
    if (!hold) begin
      start = 1'b0;
      @(posedge clk); #1;
      check_eq("done_one_cycle", done, 0);
      check_eq("busy_after", busy, 0);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_diff", diff, 0);
    check_eq("rst_bout", borrow_out, 0);
    check_eq("rst_fs", {fs_a, fs_b, fs_bin}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_busy", busy, 0);

    run_op(8'd100, 8'd37, 1'b0, 0, 0);
    run_op(8'd5, 8'd10, 1'b0, 0, 0);
    check_eq("seq_a_5", seq_a, 8'b0000_0101);
    check_eq("seq_b_10", seq_b, 8'b0000_1010);
    run_op(8'd0, 8'd0, 1'b1, 0, 0);
    run_op(8'd200, 8'd200, 1'b0, 0, 0);
    run_op(8'd0, 8'd255, 1'b1, 0, 0);
    run_op(8'd255, 8'd0, 1'b0, 0, 0);

    run_op(8'd9, 8'd4, 1'b0, 3, 0);

    run_op(8'd3, 8'd1, 1'b0, 0, 1);
    run_op(8'd7, 8'd2, 1'b0, 0, 0);

    // reset in the fourth RUN cycle
    a = 8'd50; b = 8'd20; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("busy_pre_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_diff", diff, 0);
    check_eq("midrst_bout", borrow_out, 0);
    last_diff = '0;
    last_bout = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("post_rst_busy", busy, 0);
      check_eq("post_rst_done", done, 0);
    end
    run_op(8'd50, 8'd20, 1'b0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0, 0);
    end

    check_eq("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
